// File: rtl/fb_scanout_pkg.sv
// +--------------------------------------------------------------------------+
// | fb_scanout_pkg : 640x480@60 VGA timing constants and RGB444 slices        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package fb_scanout_pkg;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] H_ACTIVE     = 10'd640;
  localparam logic [CNT_W-1:0] H_FP         = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
  localparam logic [CNT_W-1:0] H_BP         = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [CNT_W-1:0] H_LAST       = H_TOTAL - 10'd1;

  localparam logic [CNT_W-1:0] V_ACTIVE     = 10'd480;
  localparam logic [CNT_W-1:0] V_FP         = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
  localparam logic [CNT_W-1:0] V_BP         = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [CNT_W-1:0] V_LAST       = V_TOTAL - 10'd1;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +--------------------------------------------------------------------------+
// | vga_timing_gen : h/v counters, sync decode, active flag, frame_start      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
  import fb_scanout_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] h_cnt_o,
  output logic [CNT_W-1:0] v_cnt_o,
  output logic             hsync_n_o,
  output logic             vsync_n_o,
  output logic             active_o,
  output logic             line_end_o,
  output logic             frame_end_o,
  output logic             frame_start_o
);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;

  assign line_end_o  = (h_cnt_q == H_LAST);
  assign frame_end_o = line_end_o && (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_en_i) begin
      if (line_end_o) begin
        h_cnt_d = '0;
        if (frame_end_o) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_cnt_o       = h_cnt_q;
  assign v_cnt_o       = v_cnt_q;
  assign hsync_n_o     = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
  assign vsync_n_o     = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
  assign active_o      = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);
  assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// +--------------------------------------------------------------------------+
// | fb_scanout : upscaling framebuffer scan-out to 640x480 VGA, RGB444 out    |
// | Optional SCANOUT_DOUBLE_BUF_EN adds frame-aligned bank swapping.         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int COL_W    = 7,
  parameter int ROW_W    = 6,
  parameter int DATA_W   = 12,
  parameter int H_SCALE  = 5,
  parameter int V_SCALE  = 7,
  parameter int V_OFFSET = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  output logic [COL_W+ROW_W-1:0] read_addr,
  input  logic [DATA_W-1:0]      din,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
`ifdef SCANOUT_DOUBLE_BUF_EN
  ,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   bank
`endif
);

  localparam int H_SUB_W = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int V_SUB_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
  localparam logic [H_SUB_W-1:0] H_SUB_LAST  = H_SUB_W'(H_SCALE - 1);
  localparam logic [V_SUB_W-1:0] V_SUB_LAST  = V_SUB_W'(V_SCALE - 1);
  localparam logic [CNT_W-1:0]   IMG_V_START = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0]   IMG_V_END   = CNT_W'(V_OFFSET + (2**ROW_W) * V_SCALE);

  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_hsync_n, w_vsync_n, w_active;
  logic             w_line_end, w_frame_end, w_frame_start;
  logic             w_in_img_v, w_visible;

  vga_timing_gen u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_en_i      (pix_en),
    .h_cnt_o       (w_h_cnt),
    .v_cnt_o       (w_v_cnt),
    .hsync_n_o     (w_hsync_n),
    .vsync_n_o     (w_vsync_n),
    .active_o      (w_active),
    .line_end_o    (w_line_end),
    .frame_end_o   (w_frame_end),
    .frame_start_o (w_frame_start)
  );

  assign w_in_img_v = (w_v_cnt >= IMG_V_START) && (w_v_cnt < IMG_V_END);
  assign w_visible  = (w_h_cnt < H_ACTIVE) && w_in_img_v;

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [H_SUB_W-1:0] h_sub_q, h_sub_d;
  logic [V_SUB_W-1:0] v_sub_q, v_sub_d;
  logic [3:0]         red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;

  // Sub-counters replace division: col/row step once per H_SCALE/V_SCALE ticks.
  always_comb begin
    col_d   = col_q;
    h_sub_d = h_sub_q;
    row_d   = row_q;
    v_sub_d = v_sub_q;
    if (pix_en) begin
      if (w_line_end) begin
        col_d   = '0;
        h_sub_d = '0;
      end else if (w_active) begin
        if (h_sub_q == H_SUB_LAST) begin
          h_sub_d = '0;
          col_d   = col_q + 1'b1;
        end else begin
          h_sub_d = h_sub_q + 1'b1;
        end
      end
      if (w_frame_end) begin
        row_d   = '0;
        v_sub_d = '0;
      end else if (w_line_end && w_in_img_v) begin
        if (v_sub_q == V_SUB_LAST) begin
          v_sub_d = '0;
          row_d   = row_q + 1'b1;
        end else begin
          v_sub_d = v_sub_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      red_d   = w_visible ? din[R_HI:R_LO] : 4'h0;
      green_d = w_visible ? din[G_HI:G_LO] : 4'h0;
      blue_d  = w_visible ? din[B_HI:B_LO] : 4'h0;
      hsync_d = w_hsync_n;
      vsync_d = w_vsync_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      h_sub_q <= '0;
      v_sub_q <= '0;
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      h_sub_q <= h_sub_d;
      v_sub_q <= v_sub_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign read_addr   = {col_q, row_q};
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = w_frame_start;

`ifdef SCANOUT_DOUBLE_BUF_EN
  logic bank_q;

  // Swap only in the frame_start cycle so the bank is stable for a whole frame.
  assign swap_ack = w_frame_start && swap_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else if (swap_ack) begin
      bank_q <= ~bank_q;
    end
  end

  assign bank = bank_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// +--------------------------------------------------------------------------+
// | tb_fb_scanout : directed self-checking bench for fb_scanout               |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_en = 1'b0;
  logic [12:0] read_addr;
  logic [11:0] din;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frame_start;
`ifdef SCANOUT_DOUBLE_BUF_EN
  logic        swap_req = 1'b0;
  logic        swap_ack, bank;
  logic        exp_bank = 1'b0, exp_ack = 1'b0, prev_ack = 1'b0;
  bit          raise_on_fs = 1'b0;
`endif

  // RAM stand-in: data = {row[3:0], 0, col[6:0]}
  assign din = {read_addr[3:0], 1'b0, read_addr[12:6]};

  always #5 clk = ~clk;

  fb_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .read_addr   (read_addr),
    .din         (din),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
`ifdef SCANOUT_DOUBLE_BUF_EN
    ,
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .bank        (bank)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  int          bh = 0, bv = 0;
  logic [11:0] exp_rgb = '0;
  logic        exp_hs = 1'b1, exp_vs = 1'b1, exp_fs = 1'b0;
  bit          addr_valid = 1'b1;
  int          edge_no = 0, first_fall = 0, second_fall = 0;
  int          hs_low_w = 0, vs_low = 0, fs_count = 0;
  logic        prev_hs = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (line %0d pixel %0d)", tag, obs, exp, bv, bh);
    end
  endtask

  task automatic reset_checks();
    check("rst_rgb", {red, green, blue}, 32'h0);
    check("rst_sync", {hsync, vsync}, 32'h3);
    check("rst_addr", read_addr, 32'h0);
    check("rst_frame_start", frame_start, 32'h0);
`ifdef SCANOUT_DOUBLE_BUF_EN
    check("rst_bank", bank, 32'h0);
    check("rst_swap_ack", swap_ack, 32'h0);
`endif
  endtask

  task automatic step();
    logic en;
    int   r, c;
    en = pix_en;
    @(posedge clk);
    #1;
    exp_fs = 1'b0;
    if (en) begin
      exp_hs = !(bh >= 656 && bh < 752);
      exp_vs = !(bv >= 490 && bv < 492);
      if (bh < 640 && bv >= 16 && bv < 464) begin
        r = (bv - 16) / 7;
        c = bh / 5;
        exp_rgb = {r[3:0], 1'b0, c[6:0]};
      end else begin
        exp_rgb = 12'h000;
      end
      exp_fs = (bh == 799 && bv == 524);
      if (exp_fs) addr_valid = 1'b1;
      bh++;
      if (bh == 800) begin
        bh = 0;
        bv++;
        if (bv == 525) bv = 0;
      end
      edge_no++;
      if (prev_hs && !hsync) begin
        if (first_fall == 0) first_fall = edge_no;
        else if (second_fall == 0) second_fall = edge_no;
      end
      if (!hsync && first_fall != 0 && second_fall == 0) hs_low_w++;
      if (!vsync) vs_low++;
      prev_hs = hsync;
    end
    if (frame_start) fs_count++;
`ifdef SCANOUT_DOUBLE_BUF_EN
    if (prev_ack) begin
      exp_bank = ~exp_bank;
      swap_req = 1'b0;
    end
    if (raise_on_fs && exp_fs) begin
      swap_req    = 1'b1;
      raise_on_fs = 1'b0;
      #1;
    end
    exp_ack  = exp_fs && swap_req;
    prev_ack = exp_ack;
    check("bank", bank, exp_bank);
    check("swap_ack", swap_ack, exp_ack);
`endif
    check("pixel", {red, green, blue, hsync, vsync}, {exp_rgb, exp_hs, exp_vs});
    check("frame_start", frame_start, exp_fs);
    if (addr_valid) begin
      c = (bh < 640 && bv < 480) ? bh / 5 : 0;
      r = (bv >= 16 && bv < 464) ? (bv - 16) / 7 : 0;
      check("read_addr", read_addr, {c[6:0], r[5:0]});
    end
  endtask

  task automatic run_to(input int h, input int v);
    int guard = 0;
    while (!(bh == h && bv == v) && guard < 60000) begin
      step();
      guard++;
    end
    check("run_to_bound", (guard < 60000), 32'h1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n  = 1'b1;
    pix_en = 1'b1;
    repeat (300) step();

    // Mid-line reset: counters and statistics restart from (0,0)
    rst_n = 1'b0;
    #1;
    reset_checks();
    bh = 0; bv = 0;
    exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0;
    edge_no = 0; first_fall = 0; second_fall = 0; hs_low_w = 0; vs_low = 0;
    prev_hs = 1'b1;
    #2 rst_n = 1'b1;

    run_to(0, 25);

    // One pixel strobe in four for two image lines
    repeat (1600) begin
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      repeat (3) step();
    end
    pix_en = 1'b1;
    run_to(700, 27);

`ifdef SCANOUT_DOUBLE_BUF_EN
    swap_req = 1'b1;
`endif
    force dut.u_timing.h_cnt_q = 10'd700;
    force dut.u_timing.v_cnt_q = 10'd476;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    bh = 700; bv = 476; addr_valid = 1'b0;
    run_to(700, 496);

    force dut.u_timing.h_cnt_q = 10'd700;
    force dut.u_timing.v_cnt_q = 10'd523;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    bh = 700; bv = 523;
    run_to(700, 1);

`ifdef SCANOUT_DOUBLE_BUF_EN
    raise_on_fs = 1'b1;
`endif
    force dut.u_timing.h_cnt_q = 10'd700;
    force dut.u_timing.v_cnt_q = 10'd524;
    #1;
    release dut.u_timing.h_cnt_q;
    release dut.u_timing.v_cnt_q;
    bh = 700; bv = 524; addr_valid = 1'b0;
    run_to(700, 0);

    check("hsync_first_fall", first_fall, 32'd657);
    check("line_period", second_fall - first_fall, 32'd800);
    check("hsync_width", hs_low_w, 32'd96);
    check("vsync_width", vs_low, 32'd1600);
    check("frame_start_count", fs_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
